// File: rtl/add_pipe_nbit.sv
// Pipelined N-bit adder/subtractor: carry chain cut into SEG-bit slices, one register stage per slice.
// Latency S = N/SEG edges; one op per clock; whole pipe freezes when the output is held (in_ready = out_ready | ~out_valid).
module add_pipe_nbit #(
  parameter int N   = 12,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int S = N / SEG;

  logic [S-1:0] r_v;
  logic [S-1:0] r_c;
  logic         r_sub [S];
  logic [N-1:0] r_a   [S];
  logic [N-1:0] r_b   [S];
  logic [N-1:0] r_sum [S];
  logic         r_ovf;

  logic         w_adv;
  logic [S-1:0] w_src_v;
  logic [S-1:0] w_src_c;
  logic [S-1:0] w_nxt_c;
  logic         w_src_sub [S];
  logic [N-1:0] w_src_a   [S];
  logic [N-1:0] w_src_b   [S];
  logic [N-1:0] w_bx      [S];
  logic [N-1:0] w_src_sum [S];
  logic [N-1:0] w_nxt_sum [S];
  logic [SEG:0] w_slice   [S];
  logic         w_nxt_ovf;

  assign w_adv     = out_ready | ~r_v[S-1];
  assign in_ready  = w_adv;
  assign out_valid = r_v[S-1];
  assign sum       = r_sum[S-1];
  assign cout      = r_c[S-1];
  assign ovf       = r_ovf;

  // Stage k consumes slice k of its operands; stage 0 is fed straight from the ports.
  always_comb begin
    w_src_v[0]   = in_valid;
    w_src_sub[0] = sub;
    w_src_c[0]   = cin ^ sub;
    w_src_a[0]   = a;
    w_src_b[0]   = b;
    w_src_sum[0] = '0;
    for (int k = 1; k < S; k++) begin
      w_src_v[k]   = r_v[k-1];
      w_src_sub[k] = r_sub[k-1];
      w_src_c[k]   = r_c[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_sum[k] = r_sum[k-1];
    end
    for (int k = 0; k < S; k++) begin
      w_bx[k]      = w_src_b[k] ^ {N{w_src_sub[k]}};
      w_slice[k]   = {1'b0, w_src_a[k][k*SEG +: SEG]} + {1'b0, w_bx[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, w_src_c[k]};
      w_nxt_sum[k] = w_src_sum[k];
      w_nxt_sum[k][k*SEG +: SEG] = w_slice[k][SEG-1:0];
      w_nxt_c[k]   = w_slice[k][SEG];
    end
    // Same-sign operands producing an opposite-sign result == carry-in(MSB) ^ carry-out(MSB).
    w_nxt_ovf = (w_src_a[S-1][N-1] ~^ w_bx[S-1][N-1])
              & (w_slice[S-1][SEG-1] ^ w_src_a[S-1][N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < S; k++) begin
        r_sub[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_adv) begin
      r_v <= w_src_v;
      for (int k = 0; k < S; k++) begin
        if (w_src_v[k]) begin
          r_sub[k] <= w_src_sub[k];
          r_a[k]   <= w_src_a[k];
          r_b[k]   <= w_src_b[k];
          r_c[k]   <= w_nxt_c[k];
          r_sum[k] <= w_nxt_sum[k];
        end
      end
      if (w_src_v[S-1]) r_ovf <= w_nxt_ovf;
    end
  end

endmodule

// File: tb/tb_add_pipe_nbit.sv
// Scoreboard bench for add_pipe_nbit: directed vectors, stall, mid-flight reset on N=12/SEG=4,
// plus random sweeps on N=16/SEG=16 and N=32/SEG=8.
module tb_add_pipe_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // main instance, N=12 SEG=4
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [11:0] a, b, sum;
  // sweep instance 1, N=16 SEG=16
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [15:0] a1, b1, sum1;
  // sweep instance 2, N=32 SEG=8
  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [31:0] a2, b2, sum2;

  logic [65:0] q0[$];
  logic [65:0] q1[$];
  logic [65:0] q2[$];

  add_pipe_nbit #(.N(12), .SEG(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  add_pipe_nbit #(.N(16), .SEG(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .cout(cout1), .ovf(ovf1));

  add_pipe_nbit #(.N(32), .SEG(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
    .cout(cout2), .ovf(ovf2));

  task automatic chk(string nm, logic [65:0] act, logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Packed result: {ovf, cout, sum zero-extended to 64 bits}
  function automatic logic [65:0] res(logic ov, logic co, logic [63:0] s);
    return {ov, co, s};
  endfunction

  function automatic logic [65:0] model(int w, logic [63:0] ai, logic [63:0] bi, logic ci, logic si);
    logic [63:0] mask, am, bx, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    am   = ai & mask;
    bx   = (si ? ~bi : bi) & mask;
    full = {1'b0, am} + {1'b0, bx} + {64'd0, ci ^ si};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  // Main monitor: pops on every output transfer, checks hold stability and in_ready while stalled.
  logic        held = 1'b0;
  logic [65:0] hold_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else if (out_valid && !out_ready) begin
      chk("stall_in_ready", {65'd0, in_ready}, 66'd0);
      if (held) chk("stall_hold", res(ovf, cout, {52'd0, sum}), hold_v);
      hold_v = res(ovf, cout, {52'd0, sum});
      held   = 1'b1;
    end else begin
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL main_unexpected: got sum=%h with nothing expected", sum);
        end else begin
          chk("main_result", res(ovf, cout, {52'd0, sum}), q0.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL s1_unexpected: got sum=%h with nothing expected", sum1);
      end else chk("s1_result", res(ovf1, cout1, {48'd0, sum1}), q1.pop_front());
    end
    if (rst_n && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL s4_unexpected: got sum=%h with nothing expected", sum2);
      end else chk("s4_result", res(ovf2, cout2, {32'd0, sum2}), q2.pop_front());
    end
  end

  task automatic send0(logic [11:0] av, logic [11:0] bv, logic ci, logic si, logic [65:0] ex, bit track);
    bit acc;
    a = av; b = bv; cin = ci; sub = si; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (track) q0.push_back(ex);
        in_valid = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 40 && q0.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("main_drained", 66'(q0.size()), 66'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [11:0] ra, rb;
    logic rc, rs;

    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; out_ready1 = 1;
    in_valid2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; out_ready2 = 1;
    #12;
    chk("reset_out_valid", {65'd0, out_valid}, 66'd0);
    chk("reset_outputs", res(ovf, cout, {52'd0, sum}), 66'd0);
    chk("reset_in_ready", {65'd0, in_ready}, 66'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Carry wrap, with latency measurement on an empty pipe
    send0(12'hFFF, 12'h001, 0, 0, res(0, 1, 64'h000), 1);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency_s3", 66'(lat), 66'd3);
    drain0();

    send0(12'h800, 12'h001, 0, 1, res(1, 1, 64'h7FF), 1);
    send0(12'h005, 12'h007, 1, 1, res(0, 0, 64'hFFD), 1);
    send0(12'h7FF, 12'h001, 0, 0, res(1, 0, 64'h800), 1);
    send0(12'h000, 12'h000, 0, 1, res(0, 1, 64'h000), 1);
    send0(12'hABC, 12'h543, 1, 0, res(0, 1, 64'h000), 1);
    send0(12'h123, 12'h456, 0, 0, res(0, 0, 64'h579), 1);
    drain0();

    // Back-to-back stream with a 4-cycle stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = 12'($urandom); rb = 12'($urandom);
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send0(ra, rb, rc, rs, model(12, {52'd0, ra}, {52'd0, rb}, rc, rs), 1);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain0();

    // Reset while two ops are in flight and the output is held
    out_ready = 1'b0;
    send0(12'h111, 12'h222, 0, 0, 66'd0, 0);
    send0(12'h333, 12'h444, 0, 0, 66'd0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("midrst_outputs", res(ovf, cout, {52'd0, sum}), 66'd0);
    chk("midrst_in_ready", {65'd0, in_ready}, 66'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send0(12'h123, 12'h456, 0, 0, res(0, 0, 64'h579), 1);
    drain0();

    // Parameter sweep: both instances run concurrently with out_ready held high
    fork
      begin
        a1 = 16'h8000; b1 = 16'h8000; cin1 = 0; sub1 = 0; in_valid1 = 1;
        q1.push_back(res(1, 1, 64'h0000));
        @(posedge clk); #1;
        in_valid1 = 0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid1) break;
          @(posedge clk);
          lat++;
        end
        chk("latency_s1", 66'(lat), 66'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
          a1 = 16'($urandom); b1 = 16'($urandom);
          cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
          in_valid1 = 1;
          q1.push_back(model(16, {48'd0, a1}, {48'd0, b1}, cin1, sub1));
          @(posedge clk); #1;
        end
        in_valid1 = 0;
      end
      begin
        int lat2;
        a2 = 32'h7FFF_FFFF; b2 = 32'hFFFF_FFFF; cin2 = 0; sub2 = 1; in_valid2 = 1;
        q2.push_back(res(1, 0, 64'h8000_0000));
        @(posedge clk); #1;
        in_valid2 = 0;
        lat2 = 1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid2) break;
          @(posedge clk);
          lat2++;
        end
        chk("latency_s4", 66'(lat2), 66'd4);
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
          a2 = $urandom; b2 = $urandom;
          cin2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
          in_valid2 = 1;
          q2.push_back(model(32, {32'd0, a2}, {32'd0, b2}, cin2, sub2));
          @(posedge clk); #1;
        end
        in_valid2 = 0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("s1_drained", 66'(q1.size()), 66'd0);
    chk("s4_drained", 66'(q2.size()), 66'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_pipe_nbit.md
# add_pipe_nbit

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake. It is the next generation of the team's 12-bit ripple adder. The carry chain is cut into SEG-bit slices with one register stage per slice, so the design sustains one operation per clock at any width. The block sits between the Vedic partial-product stage and the accumulation/output logic of the multiplier datapath. It replaces the fixed-width combinational adders where timing closure needs registered carry chains.

## Interface
- N, default 12: operand and result width in bits; must be a multiple of SEG.
- SEG, default 4: slice width in bits; number of pipeline stages S = N/SEG.
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  operand A (unsigned or two's complement).
- b  input  N  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  N  result.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; c0 = cin ^ sub. So sub=1, cin=0 gives a-b, and sub=1, cin=1 gives a-b-1.
- Result = a + B' + c0, computed modulo 2^N. cout = bit N of the full sum.
- ovf = carry into bit N-1 XOR carry out of bit N-1.
- Stage k (0..S-1) adds slice [k*SEG +: SEG] of the skewed operands with the carry registered from stage k-1. Stage 0 uses c0.
- Operand slices not yet consumed travel in skew registers alongside. Completed sum slices travel in deskew registers, so all of sum is aligned at the output.
- The sub flag is captured with the operands at stage 0 and applied to every slice.
- Each stage has a valid bit v[k]. out_valid = v[S-1].
- Global advance: adv = out_ready | ~out_valid. in_ready = adv, which is purely combinational from out_ready and out_valid.
- On adv: v[0] <= in_valid; v[k] <= v[k-1]; data registers shift one stage.
- When adv = 0, every register holds, including bubbles.
- Data registers load only when adv = 1 and the incoming stage valid is 1. Bubbles never corrupt held data.
- A transfer happens on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Results leave in acceptance order. None are dropped or duplicated.
- Reset (rst_n = 0, any time, asynchronous):
  - all v[k] = 0 and all data, carry and skew registers = 0;
  - outputs: out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1;
  - in-flight operations are discarded.
- Deassertion of rst_n is synchronised externally. The first accept can occur on the first rising edge with rst_n = 1.
- S = 1 (SEG = N) is legal: a single registered ripple adder with latency 1.

## Timing
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+S-1 when not stalled. For N=12, SEG=4 this is 3 edges, counting the accepting edge as edge 1.
- Throughput: 1 operation per cycle while out_ready = 1.
- Stall: out_valid = 1 & out_ready = 0 freezes the pipe. in_ready drops in the same cycle.
- sum, cout and ovf stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous accept and emit in one cycle is normal operation.
- Back-pressure released while the pipe is full: the pipe resumes on the next edge with no loss.
- Critical path: one SEG-bit ripple plus carry register. No combinational path from a/b to any output.
- in_ready depends combinationally only on out_ready and out_valid.

## Test plan
- Add with carry wrap (N=12, SEG=4): a=0xFFF, b=0x001, sub=0, cin=0 -> 3 edges later sum=0x000, cout=1, ovf=0.
- Subtract with signed overflow: a=0x800, b=0x001, sub=1, cin=0 -> sum=0x7FF, cout=1, ovf=1.
- Subtract with borrow-in: a=0x005, b=0x007, sub=1, cin=1 -> sum=0xFFD, cout=0, ovf=0.
- Streaming and stall: issue 8 back-to-back random ops with out_ready=1. Drop out_ready for 4 cycles mid-stream. Check in_ready=0 during the stall, held outputs stable, all 8 results in order, matching a reference model.
- Reset mid-flight: accept 2 ops, assert rst_n=0 between edges. Check out_valid, sum, cout and ovf all go to 0 immediately and in_ready=1. After release, a new op 0x123+0x456 yields 0x579 with no stale results.
- Parameter sweep: N=16, SEG=16 (S=1) and N=32, SEG=8 (S=4). Check latency equals S edges and that 1000 random add/sub ops match the model.
